// File: rtl/conv_mac_sched_if.sv
// Handshake bundle for conv_mac_sched: weight writes,
// window input stream and result output stream.
interface conv_mac_sched_if #(
  parameter int TAPS  = 9,
  parameter int ACC_W = 12
);
  logic                w_we;
  logic [3:0]          w_addr;
  logic [3:0]          w_data;
  logic                in_valid;
  logic                in_ready;
  logic [TAPS*4-1:0]   in_window;
  logic                out_valid;
  logic                out_ready;
  logic [ACC_W-1:0]    out_data;
  logic                busy;

  modport master (
    output w_we, w_addr, w_data,
    output in_valid, in_window, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  w_we, w_addr, w_data,
    input  in_valid, in_window, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/conv_mac_sched.sv
// Time-multiplexed 3x3 conv MAC over one shared Vedic 4x4 multiplier.
// Optional CONV_MAC_SAT_EN clamps the emitted result to 255.
module vedic_mul_2x2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic c1;
  assign c1   = a[1] & b[0] & a[0] & b[1];
  assign p[0] = a[0] & b[0];
  assign p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
  assign p[2] = (a[1] & b[1]) ^ c1;
  assign p[3] = a[1] & b[1] & c1;
endmodule

module Vedic_mul_4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [3:0] q0, q1, q2, q3;
  logic [5:0] mid;

  vedic_mul_2x2 u_ll (.a(a[1:0]), .b(b[1:0]), .p(q0));
  vedic_mul_2x2 u_hl (.a(a[3:2]), .b(b[1:0]), .p(q1));
  vedic_mul_2x2 u_lh (.a(a[1:0]), .b(b[3:2]), .p(q2));
  vedic_mul_2x2 u_hh (.a(a[3:2]), .b(b[3:2]), .p(q3));

  // cross terms plus the carry-out of the low partial product
  assign mid    = 6'(q1) + 6'(q2) + 6'(q0[3:2]);
  assign p[1:0] = q0[1:0];
  assign p[7:2] = mid + {q3, 2'b00};
endmodule

module conv_mac_sched #(
  parameter int TAPS  = 9,
  parameter int ACC_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  conv_mac_sched_if.slave   bus
);
  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DONE
  } state_t;

  localparam logic [3:0] LAST = 4'(TAPS - 1);
  localparam logic [3:0] NTAP = 4'(TAPS);

  state_t            state;
  logic [3:0]        tap;
  logic [TAPS*4-1:0] win;
  logic [TAPS*4-1:0] wts;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  sum;
  logic [ACC_W-1:0]  res;
  logic [3:0]        pix;
  logic [3:0]        wt;
  logic [7:0]        prod;
  logic              ready_q;
  logic              valid_q;
  logic              busy_q;
  logic [ACC_W-1:0]  data_q;

  assign pix = win[{tap, 2'b00} +: 4];
  assign wt  = wts[{tap, 2'b00} +: 4];

  Vedic_mul_4x4 u_mul (.a(pix), .b(wt), .p(prod));

  assign sum = acc + ACC_W'(prod);

`ifdef CONV_MAC_SAT_EN
  assign res = (sum > ACC_W'(255)) ? ACC_W'(255) : sum;
`else
  assign res = sum;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wts <= '0;
    end else if (state == IDLE && bus.w_we && bus.w_addr < NTAP) begin
      wts[{bus.w_addr, 2'b00} +: 4] <= bus.w_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tap     <= '0;
      acc     <= '0;
      win     <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            win     <= bus.in_window;
            acc     <= '0;
            tap     <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state   <= MAC;
          end
        end
        MAC: begin
          acc <= sum;
          if (tap == LAST) begin
            data_q  <= res;
            valid_q <= 1'b1;
            state   <= DONE;
          end else begin
            tap <= tap + 4'd1;
          end
        end
        DONE: begin
          // result and valid stay frozen until the writer takes them
          if (bus.out_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = ready_q;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_conv_mac_sched.sv
// Directed bench for conv_mac_sched: reset, sums, hold,
// ignored writes and mid-operation reset.
module tb_conv_mac_sched;
  localparam int TAPS  = 9;
  localparam int ACC_W = 12;

`ifdef CONV_MAC_SAT_EN
  localparam logic [ACC_W-1:0] MAX_EXP = 12'd255;
`else
  localparam logic [ACC_W-1:0] MAX_EXP = 12'd2025;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  conv_mac_sched_if #(.TAPS(TAPS), .ACC_W(ACC_W)) bus ();

  conv_mac_sched #(.TAPS(TAPS), .ACC_W(ACC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [TAPS*4-1:0] fill(input logic [3:0] v);
    logic [TAPS*4-1:0] r;
    for (int i = 0; i < TAPS; i++) r[i*4 +: 4] = v;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] d);
    bus.w_we   = 1'b1;
    bus.w_addr = a;
    bus.w_data = d;
    tick();
    bus.w_we   = 1'b0;
  endtask

  task automatic send(input logic [TAPS*4-1:0] w, output int lat);
    bus.in_window = w;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    if (!bus.out_valid) lat = -1;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.w_we      = 1'b0;
    bus.w_addr    = '0;
    bus.w_data    = '0;
    bus.in_valid  = 1'b0;
    bus.in_window = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    #2;
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_out_valid got=%0b want=0", bus.out_valid);
    end
    total++;
    if (bus.out_data !== 12'd0) begin
      bad++;
      $display("FAIL rst_out_data got=%0d want=0", bus.out_data);
    end
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_busy got=%0b want=0", bus.busy);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_in_ready got=%0b want=1", bus.in_ready);
    end
  endtask

  task automatic test_ones();
    int lat;
    for (int i = 0; i < TAPS; i++) wr(4'(i), 4'd1);
    send(fill(4'd15), lat);
    total++;
    if (lat !== 9) begin
      bad++;
      $display("FAIL ones_latency got=%0d want=9", lat);
    end
    total++;
    if (bus.out_data !== 12'd135) begin
      bad++;
      $display("FAIL ones_data got=%0d want=135", bus.out_data);
    end
    total++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL ones_done_flags got=busy%0b/rdy%0b want=busy1/rdy0",
               bus.busy, bus.in_ready);
    end
    drain();
    total++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL ones_after_hs got=v%0b/b%0b want=v0/b0",
               bus.out_valid, bus.busy);
    end
    total++;
    if (bus.out_data !== 12'd135) begin
      bad++;
      $display("FAIL ones_retain got=%0d want=135", bus.out_data);
    end
  endtask

  task automatic test_ramp();
    int lat;
    logic [TAPS*4-1:0] w;
    for (int i = 0; i < TAPS; i++) wr(4'(i), 4'(i));
    send(fill(4'd2), lat);
    total++;
    if (bus.out_data !== 12'd72 || lat !== 9) begin
      bad++;
      $display("FAIL ramp_flat got=%0d lat=%0d want=72 lat=9",
               bus.out_data, lat);
    end
    drain();
    for (int i = 0; i < TAPS; i++) w[i*4 +: 4] = 4'(8 - i);
    send(w, lat);
    total++;
    if (bus.out_data !== 12'd84 || lat !== 9) begin
      bad++;
      $display("FAIL ramp_desc got=%0d lat=%0d want=84 lat=9",
               bus.out_data, lat);
    end
    drain();
  endtask

  task automatic test_max();
    int lat;
    for (int i = 0; i < TAPS; i++) wr(4'(i), 4'd15);
    send(fill(4'd15), lat);
    total++;
    if (bus.out_data !== MAX_EXP || lat !== 9) begin
      bad++;
      $display("FAIL max_sum got=%0d lat=%0d want=%0d lat=9",
               bus.out_data, lat, MAX_EXP);
    end
    drain();
  endtask

  task automatic test_hold();
    int lat;
    int miss;
    send(fill(4'd1), lat);
    total++;
    if (bus.out_data !== 12'd135 || lat !== 9) begin
      bad++;
      $display("FAIL hold_first got=%0d lat=%0d want=135 lat=9",
               bus.out_data, lat);
    end
    bus.in_window = fill(4'd15);
    bus.in_valid  = 1'b1;
    miss = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.out_valid !== 1'b1 || bus.out_data !== 12'd135 ||
          bus.in_ready !== 1'b0)
        miss++;
    end
    total++;
    if (miss !== 0) begin
      bad++;
      $display("FAIL hold_stable got=%0d bad cycles want=0", miss);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL hold_release got=v%0b/r%0b want=v0/r1",
               bus.out_valid, bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    total++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL hold_next_accept got=b%0b/r%0b want=b1/r0",
               bus.busy, bus.in_ready);
    end
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    total++;
    if (bus.out_valid !== 1'b1 || lat !== 9 || bus.out_data !== MAX_EXP) begin
      bad++;
      $display("FAIL hold_second got=%0d lat=%0d want=%0d lat=9",
               bus.out_data, lat, MAX_EXP);
    end
    drain();
  endtask

  task automatic test_ignored_writes();
    int lat;
    bus.in_window = fill(4'd1);
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    tick();
    wr(4'd0, 4'd7);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 12'd135) begin
      bad++;
      $display("FAIL busy_write got=%0d v=%0b want=135 v=1",
               bus.out_data, bus.out_valid);
    end
    drain();
    wr(4'd12, 4'd3);
    wr(4'd9, 4'd0);
    send(fill(4'd1), lat);
    total++;
    if (bus.out_data !== 12'd135 || lat !== 9) begin
      bad++;
      $display("FAIL range_write got=%0d lat=%0d want=135 lat=9",
               bus.out_data, lat);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int lat;
    bus.in_window = fill(4'd15);
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.out_data !== 12'd0) begin
      bad++;
      $display("FAIL mid_rst_outputs got=v%0b/b%0b/d%0d want=v0/b0/d0",
               bus.out_valid, bus.busy, bus.out_data);
    end
    tick();
    rst = 1'b0;
    tick();
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_rst_idle got=r%0b/v%0b want=r1/v0",
               bus.in_ready, bus.out_valid);
    end
    send(fill(4'd15), lat);
    total++;
    if (bus.out_data !== 12'd0 || lat !== 9) begin
      bad++;
      $display("FAIL mid_rst_cleared got=%0d lat=%0d want=0 lat=9",
               bus.out_data, lat);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_ones();
    test_ramp();
    test_max();
    test_hold();
    test_ignored_writes();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
